// File: rtl/syncer_pulse_arb.sv
// syncer_pulse_arb
//   Round-robin arbiter that shares one req/ack toggle pulse syncer between
//   NUM_SRC single-cycle event sources in the source clock domain. Events are
//   latched per source, granted one at a time, and each grant produces one
//   registered pulse_out with the source index on evt_id. After every issue
//   the arbiter holds off HOLDOFF cycles so the syncer round trip completes.
//
//   Optional feature: define SYNCER_PULSE_ARB_STATS_EN to build the saturating
//   drop counter. Undefined, drop_cnt is tied to 0 and no counter flops exist.
//
// Ports
//   clk        in   1        source-domain clock
//   resetn     in   1        asynchronous active-low reset
//   src_pulse  in   NUM_SRC  per-source event, one event per high cycle
//   flush      in   1        synchronous clear of pending events and drop_cnt
//   pulse_out  out  1        one-cycle pulse to the pulse syncer input
//   evt_id     out  ID_W     granted source index, held until the next grant
//   pending    out  NUM_SRC  per-source pending flags (registered)
//   busy       out  1        high whenever the FSM is not idle
//   drop_cnt   out  CNT_W    saturating count of coalesced events

module syncer_pulse_arb #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned HOLDOFF = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] src_pulse,
  input  logic               flush,
  output logic               pulse_out,
  output logic [ID_W-1:0]    evt_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_pending;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_evt_id;
  logic               r_pulse_out;
  logic [HW-1:0]      r_cnt;

  logic               w_grant;
  logic               w_found;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_cand;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pending_nxt;

  // Round-robin pick: first pending source at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      w_cand = ID_W'((32'(r_ptr) + off) % NUM_SRC);
      if (!w_found && r_pending[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && w_found;
  assign w_ptr_nxt = (w_idx == ID_W'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;
  assign w_clr     = w_grant ? (NUM_SRC'(1) << w_idx) : '0;

  // A new event on the source being granted wins over the grant-clear.
  always_comb begin
    w_pending_nxt = (r_pending & ~w_clr) | src_pulse;
    if (flush) begin
      w_pending_nxt = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending   <= '0;
      r_ptr       <= '0;
      r_evt_id    <= '0;
      r_pulse_out <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_pulse_out <= w_grant;
      if (w_grant) begin
        r_evt_id <= w_idx;
        r_ptr    <= w_ptr_nxt;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= HW'(HOLDOFF - 1);
      end else if (r_state == S_HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign pulse_out = r_pulse_out;
  assign evt_id    = r_evt_id;
  assign pending   = r_pending;

`ifdef SYNCER_PULSE_ARB_STATS_EN
  localparam int unsigned SW = CNT_W + 5;

  logic [CNT_W-1:0]   r_drop_cnt;
  logic [NUM_SRC-1:0] w_drop;
  logic [SW-1:0]      w_drop_sum;

  // An event is lost when its source is already pending and not being granted.
  assign w_drop = src_pulse & r_pending & ~w_clr;

  always_comb begin
    w_drop_sum = SW'(r_drop_cnt);
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_drop_sum = w_drop_sum + SW'(w_drop[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum > SW'({CNT_W{1'b1}})) begin
      r_drop_cnt <= '1;
    end else begin
      r_drop_cnt <= w_drop_sum[CNT_W-1:0];
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_syncer_pulse_arb.sv
module tb_syncer_pulse_arb;

  logic       clk;
  logic       resetn;
  logic [3:0] src_pulse;
  logic       flush;
  logic       pulse_out;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic       busy;
  logic [7:0] drop_cnt;

  int unsigned n_checks;
  int unsigned n_fail;

  syncer_pulse_arb #(
    .NUM_SRC(4),
    .ID_W   (2),
    .HOLDOFF(8),
    .CNT_W  (8)
  ) u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .src_pulse(src_pulse),
    .flush    (flush),
    .pulse_out(pulse_out),
    .evt_id   (evt_id),
    .pending  (pending),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: wait for the edge, then settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    src_pulse = '0;
    flush     = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #2;
  endtask

  int unsigned t_last;
  int unsigned n_pulse;
  logic [1:0]  exp_id;
  logic [7:0]  exp_drop;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    src_pulse = '0;
    flush     = 1'b0;

    // 1 reset values while resetn is held low
    tick();
    tick();
    chk("rst_pulse", 32'(pulse_out), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    resetn = 1'b1;
    #2;

    // 2 single event on source 2
    src_pulse = 4'b0100;
    tick();
    src_pulse = '0;
    chk("single_pend", 32'(pending), 32'h4);
    chk("single_nopulse", 32'(pulse_out), 0);
    tick();
    chk("single_pulse", 32'(pulse_out), 1);
    chk("single_id", 32'(evt_id), 2);
    chk("single_pend_clr", 32'(pending), 0);
    chk("single_busy", 32'(busy), 1);
    tick();
    chk("single_pulse_1cyc", 32'(pulse_out), 0);
    chk("single_id_hold", 32'(evt_id), 2);

    // 3 simultaneous events from all sources
    do_reset();
    src_pulse = 4'b1111;
    tick();
    src_pulse = '0;
    chk("sim_pend", 32'(pending), 32'hF);
    n_pulse = 0;
    t_last  = 0;
    for (int unsigned t = 1; t <= 60; t++) begin
      tick();
      if (pulse_out) begin
        chk("sim_id", 32'(evt_id), n_pulse);
        if (n_pulse == 0) chk("sim_first_lat", t, 1);
        else chk("sim_gap", t - t_last, 10);
        t_last = t;
        n_pulse++;
      end
    end
    chk("sim_npulse", n_pulse, 4);
    chk("sim_drop", 32'(drop_cnt), 0);
    chk("sim_idle", 32'(busy), 0);

    // 4 sources 0 and 3 hammering every cycle
    do_reset();
    n_pulse = 0;
    exp_id  = 2'd0;
    for (int unsigned i = 0; i < 150; i++) begin
      src_pulse = 4'b1001;
      tick();
      if (pulse_out) begin
        chk("rr_id", 32'(evt_id), 32'(exp_id));
        exp_id = (exp_id == 2'd0) ? 2'd3 : 2'd0;
        n_pulse++;
      end
      if (i == 99) begin
`ifdef SYNCER_PULSE_ARB_STATS_EN
        exp_drop = 8'd188;
`else
        exp_drop = 8'd0;
`endif
        chk("rr_drop_100", 32'(drop_cnt), 32'(exp_drop));
      end
    end
    src_pulse = '0;
    chk("rr_npulse", n_pulse, 15);
`ifdef SYNCER_PULSE_ARB_STATS_EN
    exp_drop = 8'd255;
`else
    exp_drop = 8'd0;
`endif
    chk("rr_drop_sat", 32'(drop_cnt), 32'(exp_drop));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rr_flush_drop", 32'(drop_cnt), 0);
    chk("rr_flush_pend", 32'(pending), 0);

    // 5 new event on source 1 in its grant cycle
    do_reset();
    src_pulse = 4'b0010;
    tick();
    chk("col_pend", 32'(pending), 32'h2);
    tick();
    src_pulse = '0;
    chk("col_pulse", 32'(pulse_out), 1);
    chk("col_id", 32'(evt_id), 1);
    chk("col_pend_kept", 32'(pending), 32'h2);
    chk("col_drop", 32'(drop_cnt), 0);
    n_pulse = 0;
    for (int unsigned t = 1; t <= 20; t++) begin
      tick();
      if (pulse_out) begin
        chk("col_gap", t, 10);
        chk("col_id2", 32'(evt_id), 1);
        n_pulse++;
      end
    end
    chk("col_npulse", n_pulse, 1);
    chk("col_drop_end", 32'(drop_cnt), 0);

    // 6a flush during HOLD
    do_reset();
    src_pulse = 4'b0001;
    tick();
    src_pulse = '0;
    tick();
    chk("fl_pulse", 32'(pulse_out), 1);
    tick();
    src_pulse = 4'b0110;
    tick();
    src_pulse = '0;
    chk("fl_pend_set", 32'(pending), 32'h6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_pend_clr", 32'(pending), 0);
    chk("fl_busy", 32'(busy), 1);
    n_pulse = 0;
    for (int unsigned t = 0; t < 20; t++) begin
      tick();
      if (pulse_out) n_pulse++;
    end
    chk("fl_nopulse", n_pulse, 0);
    chk("fl_idle", 32'(busy), 0);

    // 6b async reset mid-HOLD
    src_pulse = 4'b1000;
    tick();
    src_pulse = '0;
    tick();
    chk("ar_pulse", 32'(pulse_out), 1);
    tick();
    tick();
    chk("ar_busy_pre", 32'(busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_id", 32'(evt_id), 0);
    chk("ar_pulse0", 32'(pulse_out), 0);
    resetn = 1'b1;
    tick();
    chk("ar_stay_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
